// File: rtl/control_unit_if.sv
// Control bus between the sequencer and the datapath it steers.
// master: the control unit (reads IR/flags, drives every select and strobe).
// slave:  the datapath (drives IR/flags, consumes the selects).
interface control_unit_if;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;

    logic [2:0]  RF_OutASel;
    logic [2:0]  RF_OutBSel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RSel;
    logic [3:0]  RF_TSel;
    logic [3:0]  ALU_FunSel;
    logic [1:0]  ARF_OutCSel;
    logic [1:0]  ARF_OutDSel;
    logic [1:0]  ARF_FunSel;
    logic [3:0]  ARF_RegSel;
    logic        IR_LH;
    logic        IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR;
    logic        Mem_CS;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic        MuxCSel;
    logic        Halted;
    logic [2:0]  SeqCnt;

    modport master (
        input  IROut, ALUOutFlag,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel, Halted, SeqCnt
    );

    modport slave (
        output IROut, ALUOutFlag,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel, Halted, SeqCnt
    );
endinterface

// File: rtl/control_unit.sv
// Instruction sequencer: fetches a 16-bit instruction as two bytes, then
// decodes it into datapath selects for one or two execute cycles.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   FETCH_L  | T0: read M[PC] into IR low byte, PC++
//   FETCH_H  | T1: read M[PC] into IR high byte, PC++
//   EXEC     | T2: first (often only) execute cycle of the opcode
//   EXEC2    | T3: memory access cycle of LDM / STM
//   HALT     | parked after HLT; only Reset leaves it
module control_unit (
    input  logic                 Clock,
    input  logic                 Reset,
    control_unit_if.master       bus
);
    typedef enum logic [2:0] {
        S_FETCH_L = 3'd0,
        S_FETCH_H = 3'd1,
        S_EXEC    = 3'd2,
        S_EXEC2   = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDI = 4'b0000;
    localparam logic [3:0] OP_LDM = 4'b0001;
    localparam logic [3:0] OP_STM = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000;
    localparam logic [3:0] OP_BRA = 4'b1010;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [1:0] FUN_INC  = 2'b01;
    localparam logic [1:0] FUN_LOAD = 2'b10;

    localparam logic [3:0] ARF_PC = 4'b0001;
    localparam logic [3:0] ARF_AR = 4'b0010;

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_IMM = 2'b10;

    state_t      state;
    state_t      state_next;
    logic [3:0]  opcode;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [3:0]  rd_onehot;
    logic        flag_z;

    assign opcode    = bus.IROut[15:12];
    assign rd        = bus.IROut[11:10];
    assign rs        = bus.IROut[9:8];
    assign rd_onehot = 4'b0001 << rd;
    assign flag_z    = bus.ALUOutFlag[3];

    // State register; reset is sampled on the clock edge and wins over everything.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= S_FETCH_L;
        end else begin
            state <= state_next;
        end
    end

    // Sequencing: LDM/STM take an extra memory cycle, HLT parks the machine.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH_L: state_next = S_FETCH_H;
            S_FETCH_H: state_next = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_LDM || opcode == OP_STM) begin
                    state_next = S_EXEC2;
                end else if (opcode == OP_HLT) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_FETCH_L;
                end
            end
            S_EXEC2:   state_next = S_FETCH_L;
            S_HALT:    state_next = S_HALT;
            default:   state_next = S_FETCH_L;
        endcase
    end

    // Datapath control decode; everything idles while Reset is held low.
    always_comb begin
        bus.RF_OutASel  = 3'b000;
        bus.RF_OutBSel  = 3'b000;
        bus.RF_FunSel   = 2'b00;
        bus.RF_RSel     = 4'b0000;
        bus.RF_TSel     = 4'b0000;
        bus.ALU_FunSel  = 4'b0000;
        bus.ARF_OutCSel = 2'b00;
        bus.ARF_OutDSel = 2'b00;
        bus.ARF_FunSel  = 2'b00;
        bus.ARF_RegSel  = 4'b0000;
        bus.IR_LH       = 1'b0;
        bus.IR_Enable   = 1'b0;
        bus.IR_Funsel   = 2'b00;
        bus.Mem_WR      = 1'b0;
        bus.Mem_CS      = 1'b1;
        bus.MuxASel     = 2'b00;
        bus.MuxBSel     = 2'b00;
        bus.MuxCSel     = 1'b0;
        if (Reset) begin
            case (state)
                S_FETCH_L, S_FETCH_H: begin
                    bus.Mem_CS      = 1'b0;
                    bus.ARF_OutDSel = 2'b00;
                    bus.IR_Enable   = 1'b1;
                    bus.IR_LH       = (state == S_FETCH_H);
                    bus.IR_Funsel   = FUN_LOAD;
                    bus.ARF_RegSel  = ARF_PC;
                    bus.ARF_FunSel  = FUN_INC;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_LDI: begin
                            bus.MuxASel   = MUX_IMM;
                            bus.RF_FunSel = FUN_LOAD;
                            bus.RF_RSel   = rd_onehot;
                        end
                        OP_LDM, OP_STM: begin
                            bus.MuxBSel    = MUX_IMM;
                            bus.ARF_RegSel = ARF_AR;
                            bus.ARF_FunSel = FUN_LOAD;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            bus.RF_OutASel = {1'b0, rd};
                            bus.RF_OutBSel = {1'b0, rs};
                            bus.MuxCSel    = 1'b0;
                            bus.MuxASel    = MUX_ALU;
                            bus.RF_FunSel  = FUN_LOAD;
                            bus.RF_RSel    = rd_onehot;
                            case (opcode)
                                OP_ADD:  bus.ALU_FunSel = 4'b0100;
                                OP_SUB:  bus.ALU_FunSel = 4'b0101;
                                OP_AND:  bus.ALU_FunSel = 4'b0111;
                                OP_OR:   bus.ALU_FunSel = 4'b1000;
                                default: bus.ALU_FunSel = 4'b1001;
                            endcase
                        end
                        OP_BRA, OP_BEQ, OP_BNE: begin
                            // Flags come straight from the ALU flag register this cycle.
                            if (opcode == OP_BRA || (opcode == OP_BEQ && flag_z)
                                    || (opcode == OP_BNE && !flag_z)) begin
                                bus.MuxBSel    = MUX_IMM;
                                bus.ARF_RegSel = ARF_PC;
                                bus.ARF_FunSel = FUN_LOAD;
                            end
                        end
                        default: ;
                    endcase
                end
                S_EXEC2: begin
                    bus.ARF_OutDSel = 2'b01;
                    bus.Mem_CS      = 1'b0;
                    if (opcode == OP_LDM) begin
                        bus.MuxASel   = MUX_MEM;
                        bus.RF_FunSel = FUN_LOAD;
                        bus.RF_RSel   = rd_onehot;
                    end else begin
                        bus.RF_OutASel = {1'b0, rd};
                        bus.MuxCSel    = 1'b0;
                        bus.ALU_FunSel = 4'b0000;
                        bus.Mem_WR     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs track the state register only.
    always_comb begin
        bus.Halted = (state == S_HALT);
        case (state)
            S_FETCH_L: bus.SeqCnt = 3'd0;
            S_FETCH_H: bus.SeqCnt = 3'd1;
            S_EXEC:    bus.SeqCnt = 3'd2;
            S_EXEC2:   bus.SeqCnt = 3'd3;
            S_HALT:    bus.SeqCnt = 3'd2;
            default:   bus.SeqCnt = 3'd0;
        endcase
    end
endmodule
